video_timing_gen: RTL and testbench

Synthesizable, parametrised video timing and test-pattern source for the image-filter pipeline. Generates `vs`/`hs`/`de` with programmable sync, back-porch, active and front-porch intervals on both axes, plus `NUM_CH` pattern-data channels, in single-frame or continuous mode. It sits in front of `rtl_top`'s video input and replaces the software frame sender for on-silicon and long-run regression.

---
 rtl/video_timing_gen.sv | 156 +++++++++++++++
 tb/tb_video_timing_gen.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// video_timing_gen: programmable vs/hs/de timing and test-pattern source.
// Define VTG_CRC_EN to add a per-frame CRC-16-CCITT of the active pixels on o_crc.
module video_timing_gen #(
    parameter int H_WIDTH    = 12,
    parameter int V_WIDTH    = 12,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CH     = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_start,
    input  logic                         i_stop,
    input  logic                         i_continuous,
    input  logic [H_WIDTH-1:0]           i_hsy,
    input  logic [H_WIDTH-1:0]           i_hbp,
    input  logic [H_WIDTH-1:0]           i_hact,
    input  logic [H_WIDTH-1:0]           i_hfp,
    input  logic [V_WIDTH-1:0]           i_vsy,
    input  logic [V_WIDTH-1:0]           i_vbp,
    input  logic [V_WIDTH-1:0]           i_vact,
    input  logic [V_WIDTH-1:0]           i_vfp,
    input  logic [1:0]                   i_pattern,
    input  logic [NUM_CH*DATA_WIDTH-1:0] i_solid,
    output logic                         o_vs,
    output logic                         o_hs,
    output logic                         o_de,
    output logic [NUM_CH*DATA_WIDTH-1:0] o_data,
    output logic                         o_busy,
    output logic                         o_frame_done,
    output logic [15:0]                  o_crc
);
    localparam int HC = H_WIDTH + 2;
    localparam int VC = V_WIDTH + 2;
    localparam int PW = NUM_CH * DATA_WIDTH;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                state_q, state_d;
    logic [H_WIDTH-1:0]    hsy_q, hbp_q, hact_q, hfp_q;
    logic [V_WIDTH-1:0]    vsy_q, vbp_q, vact_q, vfp_q;
    logic [1:0]            pat_q;
    logic [PW-1:0]         solid_q;
    logic [HC-1:0]         h_q, h_d, h_a0, h_a1, h_tot;
    logic [VC-1:0]         v_q, v_d, v_a0, v_a1, v_tot;
    logic                  vs_q, hs_q, de_q, busy_q, done_q;
    logic [PW-1:0]         data_q, pix;
    logic [DATA_WIDTH-1:0] x, y;
    logic                  run, h_last, f_end, start, again, latch, de_d;

    assign h_a0  = HC'(hsy_q) + HC'(hbp_q);
    assign h_a1  = h_a0 + HC'(hact_q);
    assign h_tot = h_a1 + HC'(hfp_q);
    assign v_a0  = VC'(vsy_q) + VC'(vbp_q);
    assign v_a1  = v_a0 + VC'(vact_q);
    assign v_tot = v_a1 + VC'(vfp_q);

    assign run    = state_q == RUN;
    assign h_last = h_q == h_tot - HC'(1);
    assign f_end  = run && h_last && v_q == v_tot - VC'(1);
    // outputs lag the counters by one cycle, so done_q marks the visible frame-end cycle
    assign start  = !run && i_start && !done_q;
    assign again  = f_end && i_continuous && !i_stop;
    assign latch  = start || again;

    assign state_d = latch ? RUN : f_end ? IDLE : state_q;
    assign h_d     = (!run || h_last) ? '0 : h_q + HC'(1);
    assign v_d     = (!run || f_end) ? '0 : h_last ? v_q + VC'(1) : v_q;

    assign de_d = run && h_q >= h_a0 && h_q < h_a1 && v_q >= v_a0 && v_q < v_a1;
    assign x    = DATA_WIDTH'(h_q - h_a0);
    assign y    = DATA_WIDTH'(v_q - v_a0);
    assign pix  = pat_q == 2'd0 ? solid_q :
                  pat_q == 2'd1 ? {NUM_CH{x}} :
                  pat_q == 2'd2 ? {NUM_CH{y}} : {PW{x[3] ^ y[3]}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            h_q     <= '0;
            v_q     <= '0;
            hsy_q   <= '0;
            hbp_q   <= '0;
            hact_q  <= '0;
            hfp_q   <= '0;
            vsy_q   <= '0;
            vbp_q   <= '0;
            vact_q  <= '0;
            vfp_q   <= '0;
            pat_q   <= '0;
            solid_q <= '0;
            vs_q    <= 1'b0;
            hs_q    <= 1'b0;
            de_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
            if (latch) begin
                hsy_q   <= i_hsy;
                hbp_q   <= i_hbp;
                hact_q  <= i_hact;
                hfp_q   <= i_hfp;
                vsy_q   <= i_vsy;
                vbp_q   <= i_vbp;
                vact_q  <= i_vact;
                vfp_q   <= i_vfp;
                pat_q   <= i_pattern;
                solid_q <= i_solid;
            end
            busy_q <= run;
            vs_q   <= run && v_q < VC'(vsy_q);
            hs_q   <= run && h_q < HC'(hsy_q);
            de_q   <= de_d;
            data_q <= de_d ? pix : '0;
            done_q <= f_end;
        end
    end

    assign o_vs         = vs_q;
    assign o_hs         = hs_q;
    assign o_de         = de_q;
    assign o_data       = data_q;
    assign o_busy       = busy_q;
    assign o_frame_done = done_q;

`ifdef VTG_CRC_EN
    logic [15:0] acc_q, acc_nx, crc_q;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [PW-1:0] d);
        logic [15:0] r;
        r = c;
        for (int i = PW - 1; i >= 0; i--)
            r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
        return r;
    endfunction

    assign acc_nx = de_q ? crc_step(acc_q, data_q) : acc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= 16'hFFFF;
            crc_q <= '0;
        end else begin
            acc_q <= done_q ? 16'hFFFF : acc_nx;
            if (done_q) crc_q <= acc_nx;
        end
    end

    assign o_crc = crc_q;
`else
    assign o_crc = '0;
`endif
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: directed and randomized frames checked against a frame-index reference model.
module tb_video_timing_gen;
    localparam int HW = 12;
    localparam int VW = 12;
    localparam int DW = 8;
    localparam int NC = 3;
    localparam int PW = NC * DW;
`ifdef VTG_CRC_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_start, i_stop, i_continuous;
    logic [HW-1:0] i_hsy, i_hbp, i_hact, i_hfp;
    logic [VW-1:0] i_vsy, i_vbp, i_vact, i_vfp;
    logic [1:0]    i_pattern;
    logic [PW-1:0] i_solid;
    logic          o_vs, o_hs, o_de, o_busy, o_frame_done;
    logic [PW-1:0] o_data;
    logic [15:0]   o_crc;

    int            passes = 0, total = 0;
    int            m_hsy, m_hbp, m_hact, m_hfp, m_vsy, m_vbp, m_vact, m_vfp, m_pat;
    logic [PW-1:0] m_solid;
    int            p_t[8];
    int            p_pat;
    logic [PW-1:0] p_solid;
    logic [15:0]   exp_crc = 16'h0;
    int            de_seen, done_at;

    video_timing_gen #(.H_WIDTH(HW), .V_WIDTH(VW), .DATA_WIDTH(DW), .NUM_CH(NC)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_stop(i_stop), .i_continuous(i_continuous),
        .i_hsy(i_hsy), .i_hbp(i_hbp), .i_hact(i_hact), .i_hfp(i_hfp),
        .i_vsy(i_vsy), .i_vbp(i_vbp), .i_vact(i_vact), .i_vfp(i_vfp),
        .i_pattern(i_pattern), .i_solid(i_solid),
        .o_vs(o_vs), .o_hs(o_hs), .o_de(o_de), .o_data(o_data),
        .o_busy(o_busy), .o_frame_done(o_frame_done), .o_crc(o_crc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic set_timing(input int hsy, hbp, hact, hfp, vsy, vbp, vact, vfp, pat,
                              input logic [PW-1:0] solid);
        i_hsy = HW'(hsy); i_hbp = HW'(hbp); i_hact = HW'(hact); i_hfp = HW'(hfp);
        i_vsy = VW'(vsy); i_vbp = VW'(vbp); i_vact = VW'(vact); i_vfp = VW'(vfp);
        i_pattern = 2'(pat);
        i_solid = solid;
    endtask

    task automatic apply_pending();
        set_timing(p_t[0], p_t[1], p_t[2], p_t[3], p_t[4], p_t[5], p_t[6], p_t[7], p_pat, p_solid);
    endtask

    task automatic rand_pending();
        p_t[0] = $urandom_range(1, 4);  p_t[1] = $urandom_range(0, 3);
        p_t[2] = $urandom_range(1, 12); p_t[3] = $urandom_range(0, 3);
        p_t[4] = $urandom_range(1, 3);  p_t[5] = $urandom_range(0, 2);
        p_t[6] = $urandom_range(1, 6);  p_t[7] = $urandom_range(0, 2);
        p_pat = $urandom_range(0, 3);
        p_solid = PW'($urandom);
    endtask

    task automatic latch_model();
        m_hsy = int'(i_hsy); m_hbp = int'(i_hbp); m_hact = int'(i_hact); m_hfp = int'(i_hfp);
        m_vsy = int'(i_vsy); m_vbp = int'(i_vbp); m_vact = int'(i_vact); m_vfp = int'(i_vfp);
        m_pat = int'(i_pattern);
        m_solid = i_solid;
    endtask

    function automatic int frame_len();
        return (m_hsy + m_hbp + m_hact + m_hfp) * (m_vsy + m_vbp + m_vact + m_vfp);
    endfunction

    // expected {busy, vs, hs, de, done, data} for cycle t of a frame
    function automatic logic [PW+4:0] model(input int t);
        int lt, h, v, x, y;
        logic de;
        logic [DW-1:0] xb, yb;
        logic [PW-1:0] d;
        lt = m_hsy + m_hbp + m_hact + m_hfp;
        h = t % lt;
        v = t / lt;
        x = h - m_hsy - m_hbp;
        y = v - m_vsy - m_vbp;
        de = x >= 0 && x < m_hact && y >= 0 && y < m_vact;
        xb = x[DW-1:0];
        yb = y[DW-1:0];
        d = m_pat == 0 ? m_solid : m_pat == 1 ? {NC{xb}} : m_pat == 2 ? {NC{yb}} : {PW{x[3] ^ y[3]}};
        return {1'b1, v < m_vsy, h < m_hsy, de, t == frame_len() - 1, de ? d : {PW{1'b0}}};
    endfunction

    function automatic logic [15:0] crc_px(input logic [15:0] c, input logic [PW-1:0] d);
        logic [15:0] r;
        r = c;
        for (int i = PW - 1; i >= 0; i--) begin
            if (r[15] ^ d[i]) r = (r << 1) ^ 16'h1021;
            else r = r << 1;
        end
        return r;
    endfunction

    task automatic run_frame(input string tag, input int start_at, input int stop_at, input int chg_at);
        int n;
        logic [PW+4:0] e;
        logic [15:0] c;
        n = frame_len();
        c = 16'hFFFF;
        de_seen = 0;
        done_at = -1;
        for (int t = 0; t < n; t++) begin
            @(negedge clk);
            e = model(t);
            chk($sformatf("%s t=%0d", tag, t), {o_busy, o_vs, o_hs, o_de, o_frame_done, o_data}, e);
            if (t == 0) chk({tag, "_crc"}, o_crc, exp_crc);
            de_seen += int'(o_de);
            if (o_frame_done && done_at < 0) done_at = t;
            if (e[PW+1]) c = crc_px(c, e[PW-1:0]);
            i_start = t == start_at;
            if (t == stop_at) i_stop = 1'b1;
            if (t == chg_at) apply_pending();
        end
        exp_crc = CRC_EN ? c : 16'h0;
    endtask

    task automatic start_frame();
        @(negedge clk);
        i_start = 1'b1;
        latch_model();
        @(negedge clk);
        i_start = 1'b0;
        chk("start_latency", {o_busy, o_vs, o_hs, o_de}, 0);
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        i_start = 1'b0;
        chk(tag, {o_busy, o_vs, o_hs, o_de, o_frame_done, o_data}, 0);
        chk({tag, "_crc"}, o_crc, exp_crc);
    endtask

    initial begin
        int n;
        i_start = 1'b0;
        i_stop = 1'b0;
        i_continuous = 1'b0;
        set_timing(1, 3, 8, 10, 3, 3, 4, 10, 1, '0);
        @(negedge clk);
        chk("reset", {o_busy, o_vs, o_hs, o_de, o_frame_done, o_data, o_crc}, 0);
        rst = 1'b0;
        idle_check("post_reset");

        // single h-ramp frame; a start pulse in the frame-done cycle must be ignored
        start_frame();
        run_frame("t1", 439, -1, -1);
        chk("t1_de_count", de_seen, 32);
        chk("t1_done_pos", done_at, 439);
        repeat (3) idle_check("t1_idle");

        // continuous run, stop raised during the third frame
        i_continuous = 1'b1;
        start_frame();
        run_frame("t2a", 50, -1, -1);
        latch_model();
        run_frame("t2b", -1, -1, -1);
        latch_model();
        run_frame("t2c", -1, 200, -1);
        idle_check("t2_idle");
        i_stop = 1'b0;

        // HACT changed mid-frame only affects the next frame
        p_t = '{1, 3, 16, 10, 3, 3, 4, 10};
        p_pat = 1;
        p_solid = '0;
        start_frame();
        run_frame("t3a", -1, -1, 100);
        chk("t3a_de_count", de_seen, 32);
        latch_model();
        run_frame("t3b", -1, 10, -1);
        chk("t3b_de_count", de_seen, 64);
        idle_check("t3_idle");
        i_stop = 1'b0;
        i_continuous = 1'b0;

        // zero porches, checkerboard
        set_timing(2, 0, 16, 0, 2, 0, 16, 0, 3, '0);
        start_frame();
        run_frame("t4", -1, -1, -1);
        chk("t4_de_count", de_seen, 256);
        idle_check("t4_idle");

        // asynchronous reset mid-frame
        set_timing(1, 3, 8, 10, 3, 3, 4, 10, 2, '0);
        start_frame();
        repeat (100) @(negedge clk);
        chk("t5_busy_before", o_busy, 1);
        #2 rst = 1'b1;
        #1 chk("t5_async_clear", {o_busy, o_vs, o_hs, o_de, o_frame_done, o_data, o_crc}, 0);
        @(negedge clk);
        rst = 1'b0;
        exp_crc = 16'h0;
        repeat (4) idle_check("t5_idle");

        // single black pixel for the CRC
        set_timing(1, 0, 1, 0, 1, 0, 1, 0, 0, '0);
        start_frame();
        run_frame("t6", -1, -1, -1);
        idle_check("t6_idle");

        // randomized intervals, patterns, modes and stray start pulses
        for (int k = 0; k < 8; k++) begin
            rand_pending();
            apply_pending();
            i_continuous = 1'($urandom_range(0, 1));
            i_stop = 1'b0;
            start_frame();
            n = frame_len();
            if (i_continuous) begin
                rand_pending();
                run_frame("rnd_a", $urandom_range(0, n - 1), -1, $urandom_range(0, n - 2));
                latch_model();
                run_frame("rnd_b", -1, 0, -1);
            end else begin
                run_frame("rnd", $urandom_range(0, n - 1), -1, -1);
            end
            idle_check("rnd_idle");
            i_stop = 1'b0;
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
